// File: rtl/pipe_pkg.sv
// Shared pipeline-register types and default payload widths.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int TAG_W  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream bundle carrying payload, control bits and dest tag.
interface pipe_stage_reg_if #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int TAG_W  = pipe_pkg::TAG_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;
  logic [TAG_W-1:0]  tag;

  modport master (
    output valid, data, ctrl, tag,
    input  ready
  );

  modport slave (
    input  valid, data, ctrl, tag,
    output ready
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with bubble insertion and flush.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant.
module pipe_stage_reg #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int TAG_W  = pipe_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  input  logic              flush,
  output logic [1:0]        occ
);

  import pipe_pkg::*;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [TAG_W-1:0]  tag_q;
  logic              in_x;
  logic              out_x;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] sk_data;
  logic [CTRL_W-1:0] sk_ctrl;
  logic [TAG_W-1:0]  sk_tag;

  // Ready comes from state only, so out_ready never reaches in_ready.
  assign up.ready = (state != SKID);
`else
  assign up.ready = (state == EMPTY) | dn.ready;
`endif

  assign in_x     = up.valid & up.ready;
  assign out_x    = dn.valid & dn.ready;
  assign dn.valid = (state != EMPTY);
  assign dn.data  = data_q;
  assign dn.ctrl  = ctrl_q;
  assign dn.tag   = tag_q;
  assign occ      = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      data_q <= '0;
      ctrl_q <= '0;
      tag_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      sk_data <= '0;
      sk_ctrl <= '0;
      sk_tag  <= '0;
`endif
    end else if (flush) begin
      state  <= EMPTY;
      ctrl_q <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_x) begin
            data_q <= up.data;
            ctrl_q <= up.ctrl;
            tag_q  <= up.tag;
            state  <= FULL;
          end
        end
        FULL: begin
          if (in_x && out_x) begin
            data_q <= up.data;
            ctrl_q <= up.ctrl;
            tag_q  <= up.tag;
`ifdef PIPE_STAGE_SKID_EN
          end else if (in_x) begin
            sk_data <= up.data;
            sk_ctrl <= up.ctrl;
            sk_tag  <= up.tag;
            state   <= SKID;
`endif
          end else if (out_x) begin
            ctrl_q <= '0;
            state  <= EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (out_x) begin
            data_q <= sk_data;
            ctrl_q <= sk_ctrl;
            tag_q  <= sk_tag;
            state  <= FULL;
          end
        end
`endif
        default: begin
          ctrl_q <= '0;
          state  <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed steps plus random traffic
// checked against a queue model of the stage.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
    logic [4:0]  t;
  } item_t;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occ;
  int         checks;
  int         errors;
  item_t      q[$];
  item_t      hold;
  logic       ordy_v;

  pipe_stage_reg_if up_if ();
  pipe_stage_reg_if dn_if ();

  pipe_stage_reg dut (
    .clk   (clk),
    .rst   (rst),
    .up    (up_if),
    .dn    (dn_if),
    .flush (flush),
    .occ   (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    if (!rst) return 1'b1;
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || ordy_v;
`endif
  endfunction

  task automatic check_outputs(string tag);
    item_t e;
    logic  v;
    v = (q.size() > 0);
    e = v ? q[0] : hold;
    chk({tag, ".occ"}, 32'(occ), 32'(q.size()));
    chk({tag, ".valid"}, 32'(dn_if.valid), 32'(v));
    chk({tag, ".in_ready"}, 32'(up_if.ready), 32'(model_ready()));
    chk({tag, ".data"}, dn_if.data, e.d);
    chk({tag, ".tag"}, 32'(dn_if.tag), 32'(e.t));
    chk({tag, ".ctrl"}, 32'(dn_if.ctrl), v ? 32'(e.c) : 32'd0);
  endtask

  // Starts and ends at a falling edge; one rising edge in between.
  task automatic step(string tag, logic iv, logic [31:0] d,
                      logic [7:0] c, logic [4:0] t,
                      logic ordy, logic fl);
    logic  ix;
    logic  ox;
    item_t it;
    up_if.valid = iv;
    up_if.data  = d;
    up_if.ctrl  = c;
    up_if.tag   = t;
    dn_if.ready = ordy;
    ordy_v      = ordy;
    flush       = fl;
    #1;
    check_outputs(tag);
    ix = iv && model_ready();
    ox = (q.size() > 0) && ordy;
    it = '{d: d, c: c, t: t};
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(it);
    end
    if (q.size() > 0) hold = q[0];
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    hold        = '0;
    rst         = 1'b0;
    flush       = 1'b0;
    ordy_v      = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    up_if.ctrl  = '0;
    up_if.tag   = '0;
    dn_if.ready = 1'b0;

    #2;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    step("first_push", 1, 32'hAA, 8'h05, 5'd3, 0, 0);
    step("first_out", 0, 32'h0, 8'h00, 5'd0, 1, 0);
    step("drained", 0, 32'h0, 8'h00, 5'd0, 1, 0);

`ifdef PIPE_STAGE_SKID_EN
    step("skid_p1", 1, 32'h11, 8'h21, 5'd1, 0, 0);
    step("skid_p2", 1, 32'h22, 8'h22, 5'd2, 0, 0);
    step("skid_full", 1, 32'h99, 8'h29, 5'd9, 0, 0);
    step("skid_pop1", 0, 32'h0, 8'h00, 5'd0, 1, 0);
    step("skid_pop2", 0, 32'h0, 8'h00, 5'd0, 1, 0);
    step("skid_empty", 0, 32'h0, 8'h00, 5'd0, 1, 0);
    step("fl_p1", 1, 32'h33, 8'h13, 5'd4, 0, 0);
    step("fl_p2", 1, 32'h44, 8'h14, 5'd5, 0, 0);
`else
    step("comb_p1", 1, 32'hAB, 8'h0B, 5'd7, 0, 0);
    step("comb_stall", 1, 32'hCD, 8'h0C, 5'd8, 0, 0);
    step("comb_go", 0, 32'h0, 8'h00, 5'd0, 1, 0);
    step("fl_p1", 1, 32'h33, 8'h13, 5'd4, 0, 0);
`endif
    step("flush", 1, 32'h55, 8'h15, 5'd6, 0, 1);
    step("post_flush", 0, 32'h0, 8'h00, 5'd0, 1, 0);

    for (int i = 0; i < 100; i++)
      step("stream", 1, 32'(i), 8'(i + 1), 5'(i), 1, 0);
    step("stream_end", 0, 32'h0, 8'h00, 5'd0, 1, 0);

    step("rst_p1", 1, 32'h66, 8'h16, 5'd10, 0, 0);
    step("rst_p2", 1, 32'h77, 8'h17, 5'd11, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    hold = '0;
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 300; i++)
      step("rand", ($urandom % 4) != 0, $urandom,
           8'($urandom), 5'($urandom),
           ($urandom % 3) != 0, ($urandom % 16) == 0);
    step("final", 0, 32'h0, 8'h00, 5'd0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width (ALU result, store data, etc.).
REQ-002 SHALL have parameter CTRL_W, default 8: control-bit width (RegWrite, MemRead, ...), zeroed on bubbles.
REQ-003 SHALL have parameter TAG_W, default 5: destination-register tag width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  upstream holds a valid item.
REQ-007 in_ready  out  1  stage can accept; registered output.
REQ-008 in_data / in_ctrl / in_tag  in  DATA_W / CTRL_W / TAG_W  upstream item.
REQ-009 out_valid  out  1  downstream item valid.
REQ-010 out_ready  in  1  downstream accepts.
REQ-011 out_data / out_ctrl / out_tag  out  DATA_W / CTRL_W / TAG_W  head item.
REQ-012 flush  in  1  discard all held items (branch mispredict / trap).
REQ-013 occ  out  2  number of held items, 0..2.

Function
REQ-014 Transfer SHALL occur on a side only when its valid and ready are both 1 at a rising edge.
REQ-015 States SHALL be EMPTY (occ=0), FULL (occ=1, main entry), SKID (occ=2, main plus skid entry).
REQ-016 EMPTY: in xfer -> FULL; else stay.
REQ-017 FULL: in xfer and out xfer -> FULL with new item; in xfer only -> SKID; out xfer only -> EMPTY.
REQ-018 SKID: out xfer -> FULL, skid entry moves to main; in_ready is 0, so no input accepted.
REQ-019 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID, taken from registered state with no combinational path from out_ready.
REQ-020 Latency SHALL be 1 cycle: an item accepted at edge N is on out_* with out_valid=1 after edge N.
REQ-021 Ordering SHALL be strict FIFO; no item is duplicated or dropped except by flush.
REQ-022 out_ctrl SHALL equal 0 whenever out_valid=0 (bubble insertion); out_data and out_tag hold their last value.
REQ-023 While out_valid=1 and out_ready=0, out_data/out_ctrl/out_tag SHALL remain stable.
REQ-024 flush=1 at an edge SHALL force EMPTY after that edge regardless of in/out activity; a simultaneous in_valid item is discarded; out_valid=0 next cycle.
REQ-025 Simultaneous out xfer and flush SHALL count as delivered downstream; the stage still empties.

Reset
REQ-026 While rst=0: state EMPTY, occ=0, out_valid=0, out_ctrl=0, out_data=0, out_tag=0, skid entry=0, in_ready=1.
REQ-027 Reset assertion mid-transfer SHALL take effect immediately (asynchronous); any held items are lost.
REQ-028 First in xfer SHALL be possible at the first rising edge after rst returns to 1.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: two-entry behaviour as REQ-015..019.
REQ-030 PIPE_STAGE_SKID_EN undefined: no skid entry or SKID state; in_ready = !out_valid | out_ready (combinational); occ max 1; all other requirements unchanged.

Structure
REQ-031 Shared package pipe_pkg SHALL hold the state enum (EMPTY/FULL/SKID) and the default width constants (DATA_W=32, CTRL_W=8, TAG_W=5).
REQ-032 SHALL be a single module with no sub-module; the EX/MEM, ID/EX and MEM/WB boundaries each instantiate it with their own CTRL_W.

Verification
REQ-033 Reset release, in_valid=1, in_data=0x0000_00AA, ctrl=0x05, tag=3 -> next cycle out_valid=1, out_data=0xAA, out_ctrl=0x05, out_tag=3, occ=1.
REQ-034 out_ready=0; push 0x11 then 0x22 -> occ=2, in_ready=0; raise out_ready -> 0x11 then 0x22 on consecutive cycles, in_ready=1 after the first pop.
REQ-035 In SKID with 0x33/0x44 held, flush=1 with in_valid=1 data 0x55 -> next cycle occ=0, out_valid=0, out_ctrl=0; 0x55 never appears.
REQ-036 Continuous in_valid=1, out_ready=1 streaming 0..99 -> 100 items out in order, one per cycle, occ stays 1.
REQ-037 Assert rst=0 asynchronously mid-cycle with occ=2 -> out_valid, out_ctrl and occ are 0 before the next clock edge.
REQ-038 Build without PIPE_STAGE_SKID_EN, out_valid=1, out_ready=0 -> in_ready=0; out_ready=1 -> in_ready=1 in the same cycle.
